// File: rtl/scene_load_seq.sv
// Scene load sequencer.
// Accepts packed voxel bytes from a host stream and unpacks each one LSB-first
// into eight single-bit writes at consecutive voxel addresses. It drives
// load_mode for the whole scene and drops it on completion, timeout or abort.
module scene_load_seq #(
  parameter int unsigned ADDR_BITS      = 15,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  input  logic [7:0]           byte_data_i,
  output logic                 load_mode_o,
  output logic                 load_valid_o,
  input  logic                 load_ready_i,
  output logic [ADDR_BITS-1:0] load_addr_o,
  output logic                 load_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  // A zero timeout still needs a one-bit timer so the declarations stay legal.
  localparam int unsigned TimerW =
      (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_BITS-1:0] AddrLast  = '1;
  localparam logic [TimerW-1:0]    TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitByte,
    StShift,
    StDone,
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shreg_q, shreg_d;
  logic [TimerW-1:0]     timer_q, timer_d;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      timer_q   <= timer_d;
    end
  end

  // Next-state logic; abort overrides everything decided in the case below.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    timer_d   = timer_q;

    case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          state_d   = StWaitByte;
          addr_d    = '0;
          bit_cnt_d = '0;
          timer_d   = '0;
        end
      end

      StWaitByte: begin
        if (byte_valid_i) begin
          shreg_d   = byte_data_i;
          bit_cnt_d = '0;
          timer_d   = '0;
          state_d   = StShift;
        end else begin
          // Saturate so a disabled timeout cannot wrap.
          if (timer_q != '1) begin
            timer_d = timer_q + TimerW'(1);
          end
          if ((TIMEOUT_CYCLES != 0) && (timer_q == TimerLast)) begin
            state_d = StError;
          end
        end
      end

      StShift: begin
        if (load_ready_i) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          addr_d    = addr_q + ADDR_BITS'(1);
          if (addr_q == AddrLast) begin
            state_d = StDone;
          end else if (bit_cnt_q == 3'd7) begin
            state_d = StWaitByte;
            timer_d = '0;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    if (abort_i) begin
      state_d   = StIdle;
      addr_d    = '0;
      bit_cnt_d = '0;
      timer_d   = '0;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    busy_o       = (state_q == StWaitByte) || (state_q == StShift);
    load_mode_o  = busy_o;
    byte_ready_o = (state_q == StWaitByte);
    load_valid_o = (state_q == StShift);
    load_addr_o  = load_valid_o ? addr_q : '0;
    load_data_o  = load_valid_o & shreg_q[0];
    done_o       = (state_q == StDone);
    error_o      = (state_q == StError);
  end

endmodule

// File: doc/scene_load_seq.md
Name: scene_load_seq

Overview:
- Sequences a full voxel-scene load into the scene loader interface from a byte-wide host stream (valid/ready).
- Unpacks each byte LSB-first into 8 single-bit voxel writes and auto-increments the voxel address from 0 to 2^ADDR_BITS-1.
- Owns load_mode and drops it when the scene is complete or when the load is aborted.
- Sits between the host/pin deserializer and the scene loader interface feeding voxel memory.

Parameters:
ADDR_BITS, 15, voxel address width; a scene is 2^ADDR_BITS voxels (must be >=3)
TIMEOUT_CYCLES, 65535, max cycles waiting for a byte before error; 0 disables the timeout

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: begin a scene load (honoured in IDLE, DONE, ERROR)
abort  input  1  pulse: cancel the load, return to IDLE
byte_valid  input  1  host byte available
byte_ready  output  1  sequencer accepts byte this cycle
byte_data  input  8  packed voxels, bit0 = lowest address
load_mode  output  1  load mode to scene loader
load_valid  output  1  voxel write request
load_ready  input  1  scene loader accepts write
load_addr  output  ADDR_BITS  voxel address
load_data  output  1  voxel occupancy bit
busy  output  1  high in WAIT_BYTE or SHIFT
done  output  1  level: scene fully written; held until next start/abort
error  output  1  level: byte timeout occurred; held until next start/abort

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset: state=IDLE, addr=0, bit_cnt=0, shreg=0, timer=0. All outputs 0.
- States: IDLE, WAIT_BYTE, SHIFT, DONE, ERROR. All outputs are decoded from registered state and registers, with no combinational path from inputs. The one exception is that byte_ready may depend only on state.
- IDLE: load_mode=0, byte_ready=0, load_valid=0.
  - start -> WAIT_BYTE; addr<=0; timer<=0.
- WAIT_BYTE: load_mode=1, byte_ready=1, load_valid=0.
  - On byte_valid (handshake): shreg<=byte_data; bit_cnt<=0; timer<=0; -> SHIFT.
  - Otherwise timer increments. If TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1, go to ERROR.
- SHIFT: load_mode=1, load_valid=1, load_addr=addr, load_data=shreg[0], byte_ready=0.
  - A write fires on load_valid && load_ready. On a fire: shreg>>=1; bit_cnt++; addr++.
  - If addr==2^ADDR_BITS-1 on the fire -> DONE. addr wraps to 0 and is not otherwise used.
  - Else if bit_cnt==7 -> WAIT_BYTE.
  - If load_ready=0, load_addr and load_data hold stable. No timeout applies in SHIFT.
- DONE: load_mode=0, done=1.
  - start -> WAIT_BYTE, done cleared, addr=0.
- ERROR: load_mode=0, error=1.
  - start -> WAIT_BYTE with error cleared.
  - The partial scene remains in memory; the scene loader's own counter resets when load_mode drops.
- abort: from any state, next state is IDLE. addr, done, error, bit_cnt and timer are cleared; load_mode=0 from the next cycle.
  - abort has priority over start, handshakes and the timeout in the same cycle.
  - A write firing in the same cycle as abort still lands in memory, since it is already accepted downstream.
- start while busy is ignored.
- Throughput: 8 voxels per 9 cycles with load_ready=1 (1 byte-accept cycle + 8 shift cycles).
- Bytes per scene = 2^ADDR_BITS/8. For ADDR_BITS=15 that is 4096 bytes and 36864 cycles minimum.
- timer width is clog2(TIMEOUT_CYCLES+1), saturating. addr is ADDR_BITS wide; bit_cnt is 3 bits.
- load_mode rises on the cycle after start is accepted and stays high continuously until DONE, ERROR or abort. There are no glitches between bytes.

Test Plan:
- ADDR_BITS=4, load_ready=1; start, then stream bytes 0xA5, 0x3C back-to-back.
  - Required: 16 writes at addr 0..15 with data 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - busy for 18 cycles, then done=1 and load_mode=0.
  - Downstream write_count=16 and load_complete=1 before load_mode falls.
- Same stream with load_ready toggled 1,0,0,1 repeating.
  - Required: no dropped or duplicated addresses; load_addr and load_data stable while stalled; done asserts.
- TIMEOUT_CYCLES=10; start, send 1 byte, then hold byte_valid=0.
  - Required: 8 writes, then error=1 exactly 10 cycles after entering WAIT_BYTE; load_mode=0; done=0.
- abort mid-SHIFT at addr=5.
  - Required: next cycle state IDLE, load_mode=0, load_valid=0; a following start restarts at addr 0.
- start and abort in the same cycle from IDLE -> stays IDLE.
- start pulsed while busy -> ignored, with no address reset.
- Assert rst_n low mid-load.
  - Required: all outputs 0 immediately (asynchronously); after release, state IDLE, ready for a fresh start.
